// File: rtl/mem_req_arbiter_pkg.sv
// +-----------------------------------------------------------------------+
// | mem_req_arbiter_pkg : shared types for the data-side request arbiter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package mem_req_arbiter_pkg;

  typedef enum logic [0:0] {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } mem_port_id_t;

  // Request fields travel as one unit so the grant mux is a single select.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    mem_port_id_t id;
    logic         discard;
  } resp_entry_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_arbiter_resp_id_queue.sv
// +-----------------------------------------------------------------------+
// | mem_req_arbiter_resp_id_queue : in-order FIFO of {id, discard}        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_req_arbiter_resp_id_queue
  import mem_req_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  mem_port_id_t  push_id,
  input  logic          pop,
  input  logic          flush,
  output resp_entry_t   head,
  output logic [CW-1:0] count,
  output logic          full
);

  resp_entry_t   entries_q [DEPTH];
  resp_entry_t   entries_d [DEPTH];
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    entries_d  = entries_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    // Marking stale slots too is harmless: a push always rewrites discard.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].discard = 1'b1;
      end
    end
    if (push) begin
      entries_d[tail_ptr_q] = '{id: push_id, discard: 1'b0};
      tail_ptr_d            = tail_ptr_q + PW'(1);
    end
    if (pop) begin
      head_ptr_d = head_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      entries_q  <= entries_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head  = entries_q[head_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// +-----------------------------------------------------------------------+
// | mem_req_arbiter : shares one dcache request port between two pipes    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,

  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic [3:0]  req0_wstrb,
  input  logic [31:0] req0_wdata,
  output logic        req0_addr_ok,
  output logic        req0_data_ok,

  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic [3:0]  req1_wstrb,
  input  logic [31:0] req1_wdata,
  output logic        req1_addr_ok,
  output logic        req1_data_ok,

  output logic [31:0] rdata,

  output logic        dc_valid,
  output logic [31:0] dc_addr,
  output logic        dc_we,
  output logic [1:0]  dc_size,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata,

  output logic        busy
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic          grant0, grant1;
  logic          can_issue;
  logic          acc;
  logic          resp;
  mem_port_id_t  grant_id;
  mem_req_t      req0, req1, req_sel;
  resp_entry_t   head;
  logic [CW-1:0] count;
  logic          full;
  logic          spurious_resp_q, spurious_resp_d;

  assign req0 = '{addr: req0_addr, we: req0_we, size: req0_size,
                  wstrb: req0_wstrb, wdata: req0_wdata};
  assign req1 = '{addr: req1_addr, we: req1_we, size: req1_size,
                  wstrb: req1_wstrb, wdata: req1_wdata};

  // Fixed priority to pipe 0 keeps older-slot requests ahead in program order.
  always_comb begin
    grant0    = req0_valid;
    grant1    = req1_valid && !req0_valid;
    grant_id  = grant1 ? PORT1 : PORT0;
    req_sel   = grant1 ? req1 : req0;
    can_issue = !flush && !full;
    dc_valid  = can_issue && (req0_valid || req1_valid);
    acc       = dc_valid && dc_addr_ok;
    resp      = dc_data_ok && (count != '0);
  end

  always_comb begin
    dc_addr      = req_sel.addr;
    dc_we        = req_sel.we;
    dc_size      = req_sel.size;
    dc_wstrb     = req_sel.wstrb;
    dc_wdata     = req_sel.wdata;
    req0_addr_ok = grant0 && can_issue && dc_addr_ok;
    req1_addr_ok = grant1 && can_issue && dc_addr_ok;
    req0_data_ok = resp && (head.id == PORT0) && !head.discard;
    req1_data_ok = resp && (head.id == PORT1) && !head.discard;
    rdata        = dc_rdata;
    busy         = (count != '0);
  end

  // Sticky debug flag for a response arriving with nothing outstanding.
  always_comb begin
    spurious_resp_d = spurious_resp_q || (dc_data_ok && (count == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spurious_resp_q <= 1'b0;
    end else begin
      spurious_resp_q <= spurious_resp_d;
    end
  end

  mem_req_arbiter_resp_id_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_id_queue (
    .clk     (clk),
    .resetn  (resetn),
    .push    (acc),
    .push_id (grant_id),
    .pop     (resp),
    .flush   (flush),
    .head    (head),
    .count   (count),
    .full    (full)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_mem_req_arbiter : directed self-checking bench for mem_req_arbiter |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [1:0]  req0_size, req1_size;
  logic [3:0]  req0_wstrb, req1_wstrb;
  logic        req0_addr_ok, req0_data_ok, req1_addr_ok, req1_data_ok;
  logic [31:0] rdata;
  logic        dc_valid, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [1:0]  dc_size;
  logic [3:0]  dc_wstrb;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we),
    .req0_size(req0_size), .req0_wstrb(req0_wstrb), .req0_wdata(req0_wdata),
    .req0_addr_ok(req0_addr_ok), .req0_data_ok(req0_data_ok),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
    .req1_size(req1_size), .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata),
    .req1_addr_ok(req1_addr_ok), .req1_data_ok(req1_data_ok),
    .rdata(rdata),
    .dc_valid(dc_valid), .dc_addr(dc_addr), .dc_we(dc_we), .dc_size(dc_size),
    .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    flush = 0; req0_valid = 0; req1_valid = 0;
    dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 32'h0;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    req0_addr = 32'h0; req0_we = 0; req0_size = 2'd2; req0_wstrb = 4'hF; req0_wdata = 32'h0;
    req1_addr = 32'h0; req1_we = 0; req1_size = 2'd2; req1_wstrb = 4'hF; req1_wdata = 32'h0;

    // Reset state
    settle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dc_valid", 32'(dc_valid), 0);
    chk("rst_data_ok", 32'({req0_data_ok, req1_data_ok}), 0);
    chk("rst_count", 32'(dut.count), 0);
    tick(); tick();
    resetn = 1;
    tick();

    // Single load from pipe 0, response two cycles after accept
    req0_valid = 1; req0_addr = 32'h1000; dc_addr_ok = 1;
    settle();
    chk("sl_dc_valid", 32'(dc_valid), 1);
    chk("sl_dc_addr", dc_addr, 32'h1000);
    chk("sl_addr_ok", 32'({req0_addr_ok, req1_addr_ok}), 32'b10);
    tick();
    req0_valid = 0; dc_addr_ok = 0;
    settle();
    chk("sl_busy1", 32'(busy), 1);
    chk("sl_addr_ok_once", 32'(req0_addr_ok), 0);
    chk("sl_no_data_early", 32'(req0_data_ok), 0);
    tick();
    dc_data_ok = 1; dc_rdata = 32'hDEADBEEF;
    settle();
    chk("sl_busy2", 32'(busy), 1);
    chk("sl_data_ok", 32'({req0_data_ok, req1_data_ok}), 32'b10);
    chk("sl_rdata", rdata, 32'hDEADBEEF);
    tick();
    dc_data_ok = 0;
    settle();
    chk("sl_busy_done", 32'(busy), 0);

    // Both pipes valid: pipe 0 first, then pipe 1
    tick();
    req0_valid = 1; req0_addr = 32'h2000; req1_valid = 1; req1_addr = 32'h3000; dc_addr_ok = 1;
    settle();
    chk("bp_c0_addr", dc_addr, 32'h2000);
    chk("bp_c0_ok", 32'({req0_addr_ok, req1_addr_ok}), 32'b10);
    tick();
    req0_valid = 0;
    settle();
    chk("bp_c1_addr", dc_addr, 32'h3000);
    chk("bp_c1_ok", 32'({req0_addr_ok, req1_addr_ok}), 32'b01);
    tick();
    req1_valid = 0; dc_addr_ok = 0; dc_data_ok = 1; dc_rdata = 32'h11111111;
    settle();
    chk("bp_r0", 32'({req0_data_ok, req1_data_ok}), 32'b10);
    tick();
    dc_rdata = 32'h22222222;
    settle();
    chk("bp_r1", 32'({req0_data_ok, req1_data_ok}), 32'b01);
    chk("bp_r1_rdata", rdata, 32'h22222222);
    tick();
    dc_data_ok = 0;
    settle();
    chk("bp_empty", 32'(dut.count), 0);

    // Fill to four outstanding, then verify the no-bypass stall
    req0_valid = 1; dc_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 32'h4000 + 32'(i * 4);
      settle();
      chk("fill_ok", 32'(req0_addr_ok), 1);
      tick();
    end
    req0_addr = 32'h4010;
    settle();
    chk("full_count", 32'(dut.count), 4);
    chk("full_dc_valid", 32'(dc_valid), 0);
    chk("full_addr_ok", 32'(req0_addr_ok), 0);
    dc_data_ok = 1;
    settle();
    chk("full_pop_no_bypass", 32'(dc_valid), 0);
    chk("full_pop_data_ok", 32'(req0_data_ok), 1);
    tick();
    dc_data_ok = 0;
    settle();
    chk("resume_dc_valid", 32'(dc_valid), 1);
    chk("resume_addr_ok", 32'(req0_addr_ok), 1);
    tick();
    req0_valid = 0; dc_addr_ok = 0; dc_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_data_ok", 32'({req0_data_ok, req1_data_ok}), 32'b10);
      tick();
    end
    dc_data_ok = 0;
    settle();
    chk("drain_count", 32'(dut.count), 0);

    // Flush with ids 0,1,0 outstanding
    dc_addr_ok = 1;
    req0_valid = 1; tick();
    req0_valid = 0; req1_valid = 1; tick();
    req1_valid = 0; req0_valid = 1; tick();
    flush = 1;
    settle();
    chk("fl_count", 32'(dut.count), 3);
    chk("fl_blocked", 32'({dc_valid, req0_addr_ok}), 0);
    tick();
    flush = 0; req0_valid = 0; req1_valid = 1; req1_addr = 32'h5000;
    settle();
    chk("fl_new_ok", 32'(req1_addr_ok), 1);
    tick();
    req1_valid = 0; dc_addr_ok = 0; dc_data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fl_discard", 32'({req0_data_ok, req1_data_ok}), 0);
      tick();
    end
    settle();
    chk("fl_new_route", 32'({req0_data_ok, req1_data_ok}), 32'b01);
    tick();
    dc_data_ok = 0;
    settle();
    chk("fl_count0", 32'(dut.count), 0);

    // Simultaneous push and pop at count 2, across pointer wrap
    exp_q.delete();
    req0_valid = 1; dc_addr_ok = 1;
    tick(); exp_q.push_back(0);
    tick(); exp_q.push_back(0);
    dc_data_ok = 1;
    for (int i = 0; i < 8; i++) begin
      int p;
      int h;
      p = i % 2;
      req0_valid = (p == 0); req1_valid = (p == 1);
      h = exp_q.pop_front();
      settle();
      chk("pp_count", 32'(dut.count), 2);
      chk("pp_route", 32'({req0_data_ok, req1_data_ok}), (h == 0) ? 32'b10 : 32'b01);
      chk("pp_addr_ok", 32'({req0_addr_ok, req1_addr_ok}), (p == 0) ? 32'b10 : 32'b01);
      exp_q.push_back(p);
      tick();
    end
    req0_valid = 0; req1_valid = 0; dc_addr_ok = 0;
    for (int i = 0; i < 2; i++) begin
      int h;
      h = exp_q.pop_front();
      settle();
      chk("pp_drain", 32'({req0_data_ok, req1_data_ok}), (h == 0) ? 32'b10 : 32'b01);
      tick();
    end

    // Spurious response while empty
    settle();
    chk("sp_no_pulse", 32'({req0_data_ok, req1_data_ok}), 0);
    tick();
    dc_data_ok = 0;
    settle();
    chk("sp_count", 32'(dut.count), 0);
    chk("sp_flag", 32'(dut.spurious_resp_q), 1);

    // Asynchronous reset mid-stream
    req0_valid = 1; dc_addr_ok = 1;
    tick();
    req0_valid = 0; dc_addr_ok = 0; dc_data_ok = 1;
    settle();
    chk("ar_busy_before", 32'(busy), 1);
    resetn = 0;
    #1;
    chk("ar_outputs", 32'({dc_valid, req0_addr_ok, req1_addr_ok, req0_data_ok, req1_data_ok, busy}), 0);
    chk("ar_count", 32'(dut.count), 0);
    chk("ar_flag", 32'(dut.spurious_resp_q), 0);
    idle_inputs();
    tick();
    resetn = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
